fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a request/grant/response handshake, with at most one request outstanding.
- Buffers returned words with their PCs in a small FIFO and presents them to decode under a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute, which flush the buffer and discard any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address, word aligned
- imem_gnt  in  1  memory accepts request this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  read data valid; earliest one cycle after grant
- imem_rdata  in  32  fetched instruction word
- redirect_valid  in  1  change of flow
- redirect_pc  in  32  new fetch PC
- inst_valid  out  1  buffer head valid toward decode
- inst_ready  in  1  decode accepts head
- instruction  out  32  instruction word to decode
- inst_pc  out  32  PC of that instruction
- fetch_fault  out  1  misaligned redirect flag (see Optional Feature)

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, buffer empty, imem_req=0, inst_valid=0, instruction=0, inst_pc=0, fetch_fault=0. Reset mid-transaction abandons everything; a response arriving after reset is ignored (no request outstanding).
- imem_req is asserted from the first cycle after rst deasserts, with imem_addr=pc.
- States:
  - FETCH: imem_req=(count+pending < BUF_DEPTH). On req&gnt, pc<=pc+4 and go to WAIT.
  - WAIT: imem_req=0. On rvalid, push {rdata, pc_of_request} and go to FETCH.
  - DROP: imem_req=0. On rvalid, discard the data and go to FETCH.
- A one-entry register holds the PC of the outstanding request.
- No back-to-back issue in the grant cycle of rvalid. Peak throughput is 1 instruction per 2 cycles.
- Latency: a grant in cycle N with rvalid in N+1 gives inst_valid in N+2 (data registered into the buffer).
- Output side:
  - inst_valid = buffer not empty; instruction and inst_pc come from the head.
  - Pop on inst_valid&inst_ready.
  - Head fields hold stable while valid and not ready.
  - Push and pop in the same cycle are legal, including when full-1.
- Flow control: space is reserved at issue, so a push never overflows and rvalid is never back-pressured.
- Redirect has priority over all other events in its cycle:
  - Buffer flushed (count=0); a same-cycle pop is ignored.
  - pc<=redirect_pc; issue resumes next cycle at redirect_pc.
  - In FETCH with a same-cycle grant: that request is orphaned, go to DROP.
  - In FETCH with no grant: stay in FETCH. A pending ungranted req is withdrawn; the address changes next cycle.
  - In WAIT with no rvalid: go to DROP.
  - In WAIT with same-cycle rvalid: data discarded, go to FETCH.
  - In DROP: stay in DROP, pc updated. A same-cycle rvalid counts as the drop, go to FETCH.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- imem_addr[1:0] is always 0.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro:
  - redirect_valid with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky) and inhibits issue; the buffer is flushed.
  - The next aligned redirect clears fetch_fault and resumes fetching.
  - rst clears fetch_fault.
- Without the macro: fetch_fault is tied to 0 and redirect_pc[1:0] is forced to 0.

Decomposition:
- Add to defines.v: RESET_PC default, fetch state encodings (FETCH_ST_FETCH/WAIT/DROP, 2 bits), NOP word 32'h0000_0013.
- One sub-module: fetch_buffer, a synchronous FIFO of BUF_DEPTH x 64 bits {pc, instr}.
  - Ports: push, pop, flush, full, empty, count, head.
  - flush has priority over push and pop.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after each grant, inst_ready=1, memory returns addr-as-data → imem_addr sequence 0,4,8; instruction/inst_pc pairs (0,0),(4,4),(8,8); first inst_valid 3 cycles after rst falls.
- inst_ready=0 for 10 cycles → exactly BUF_DEPTH=2 words buffered, imem_req low, head holds PC 0; raising ready drains in order with no loss.
- Redirect to 32'h100 in WAIT, rvalid one cycle later with 32'hDEAD → DEAD never appears; the next instruction has inst_pc=32'h100.
- Redirect to 32'h200 in the same cycle as rvalid, with ready=1 and a full buffer → buffer empty next cycle; next imem_addr=32'h200 one cycle later.
- RESET_PC=32'hFFFF_FFFC → second fetch address is 32'h0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=32'h102 → fetch_fault=1, no imem_req; a later redirect to 32'h104 clears the fault and fetches 32'h104. Without the macro, the same stimulus fetches 32'h100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_ST_FETCH = 2'd0,
    FETCH_ST_WAIT  = 2'd1,
    FETCH_ST_DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// flush empties the FIFO and overrides any same-cycle push or pop.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [63:0]                push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [63:0]                head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, buffer to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t  state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   req_pc_reg;
  logic          req_reg, req_next;
  logic          fault_next;
  logic [31:0]   redirect_target;
  logic          grant;
  logic          buf_push, buf_pop, buf_full, buf_empty;
  logic [CW-1:0] buf_count, count_next;
  fetch_entry_t  push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_reg;

  assign redirect_target = redirect_pc;
  assign fault_next      = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_reg;
  assign fetch_fault     = fault_reg;

  always_ff @(posedge clk) begin
    if (rst) fault_reg <= 1'b0;
    else     fault_reg <= fault_next;
  end
`else
  assign redirect_target = word_align(redirect_pc);
  assign fault_next      = 1'b0;
  assign fetch_fault     = 1'b0;
`endif

  assign grant      = req_reg & imem_gnt;
  assign imem_req   = req_reg;
  assign imem_addr  = word_align(pc_reg);
  assign inst_valid = ~buf_empty;
  // Redirect flushes the buffer, so neither a pop nor a push may land in that cycle.
  assign buf_pop    = inst_valid & inst_ready & ~redirect_valid;
  assign buf_push   = (state_reg == FETCH_ST_WAIT) & imem_rvalid & ~redirect_valid
                      & (~buf_full | buf_pop);
  assign push_entry = '{pc: req_pc_reg, instr: imem_rdata};
  assign count_next = redirect_valid ? '0
                    : buf_count + CW'(buf_push) - CW'(buf_pop);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      FETCH_ST_FETCH: begin
        if (grant) begin
          state_next = redirect_valid ? FETCH_ST_DROP : FETCH_ST_WAIT;
          pc_next    = pc_reg + 32'd4;
        end
      end
      FETCH_ST_WAIT: begin
        if (imem_rvalid)         state_next = FETCH_ST_FETCH;
        else if (redirect_valid) state_next = FETCH_ST_DROP;
      end
      FETCH_ST_DROP: begin
        if (imem_rvalid) state_next = FETCH_ST_FETCH;
      end
      default: state_next = FETCH_ST_FETCH;
    endcase
    if (redirect_valid) pc_next = redirect_target;
  end

  // Request is registered; buffer space is reserved by counting only what is already held.
  assign req_next = (state_next == FETCH_ST_FETCH) && (count_next < CW'(BUF_DEPTH)) && !fault_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FETCH_ST_FETCH;
      pc_reg     <= RESET_PC;
      req_pc_reg <= '0;
      req_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      req_reg   <= req_next;
      if (grant) req_pc_reg <= pc_reg;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (push_entry),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count),
    .head      (head_entry)
  );

  assign instruction = buf_empty ? 32'h0 : head_entry.instr;
  assign inst_pc     = buf_empty ? 32'h0 : head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small imem responder and pop scoreboard.
// Build with FETCH_MISALIGN_CHECK_EN defined to exercise the fault path.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, fetch_fault;
  logic [31:0] instruction, inst_pc;

  logic        w_req, w_rvalid, w_inst_valid, w_fault;
  logic [31:0] w_addr, w_rdata, w_instruction, w_inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .instruction(w_instruction),
    .inst_pc(w_inst_pc), .fetch_fault(w_fault)
  );

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  bit          busy = 0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  bit          ovr_en = 0;
  logic [31:0] ovr_data = '0;
  logic [31:0] addr_q[$];
  logic [31:0] w_addr_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_ins_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_0BAD;
  endfunction

  // One clock: record what the coming edge accepts, then drive the responders.
  task automatic tick();
    bit g, wg;
    logic [31:0] ga, wa;
    g  = !rst && imem_req && imem_gnt;
    ga = imem_addr;
    wg = !rst && w_req;
    wa = w_addr;
    if (g)  addr_q.push_back(ga);
    if (wg) w_addr_q.push_back(wa);
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      pop_pc_q.push_back(inst_pc);
      pop_ins_q.push_back(instruction);
    end
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b0;
    w_rvalid    = 1'b0;
    if (rst) begin
      busy = 0;
    end else begin
      if (g) begin
        busy  = 1;
        cnt   = lat;
        paddr = ga;
      end
      if (busy) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ovr_en ? ovr_data : paddr;
          ovr_en      = 0;
          busy        = 0;
        end else begin
          cnt--;
        end
      end
      if (wg) begin
        w_rvalid = 1'b1;
        w_rdata  = wa;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b0;
    inst_ready = 1'b0;
    lat = 1;
    ovr_en = 0;
    tick();
    tick();
    addr_q.delete();
    w_addr_q.delete();
    pop_pc_q.delete();
    pop_ins_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    int dead_seen;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    w_rvalid    = 1'b0;
    w_rdata     = '0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_fault", fetch_fault, 0);

    // Streaming at full rate with immediate responses.
    do_reset();
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    check("t1_valid_c2", inst_valid, 0);
    tick();
    check("t1_valid_c3", inst_valid, 1);
    repeat (6) tick();
    check("t1_addr0", qat(addr_q, 0), 32'h0);
    check("t1_addr1", qat(addr_q, 1), 32'h4);
    check("t1_addr2", qat(addr_q, 2), 32'h8);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_pop%0d_pc", i), qat(pop_pc_q, i), 32'(4 * i));
      check($sformatf("t1_pop%0d_ins", i), qat(pop_ins_q, i), 32'(4 * i));
    end
    check("t5_wrap_addr0", qat(w_addr_q, 0), 32'hFFFF_FFFC);
    check("t5_wrap_addr1", qat(w_addr_q, 1), 32'h0000_0000);

    // Decode stalled: buffer fills to depth and requests stop.
    do_reset();
    imem_gnt = 1'b1;
    inst_ready = 1'b0;
    repeat (10) tick();
    check("t2_valid", inst_valid, 1);
    check("t2_req", imem_req, 0);
    check("t2_head_pc", inst_pc, 32'h0);
    check("t2_head_ins", instruction, 32'h0);
    check("t2_grants", addr_q.size(), 2);
    inst_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_pop%0d_pc", i), qat(pop_pc_q, i), 32'(4 * i));
      check($sformatf("t2_pop%0d_ins", i), qat(pop_ins_q, i), 32'(4 * i));
    end

    // Redirect while waiting; the late response must be dropped.
    do_reset();
    imem_gnt = 1'b1;
    inst_ready = 1'b1;
    lat = 2;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    ovr_en = 1;
    ovr_data = 32'hDEAD;
    tick();
    redirect_valid = 1'b0;
    lat = 1;
    repeat (6) tick();
    check("t3_addr1", qat(addr_q, 1), 32'h100);
    check("t3_pop0_pc", qat(pop_pc_q, 0), 32'h100);
    check("t3_pop0_ins", qat(pop_ins_q, 0), 32'h100);
    dead_seen = 0;
    foreach (pop_ins_q[i]) if (pop_ins_q[i] == 32'hDEAD) dead_seen++;
    check("t3_dead_seen", dead_seen, 0);

    // Redirect coinciding with a response while the buffer is fully reserved.
    do_reset();
    imem_gnt = 1'b1;
    inst_ready = 1'b0;
    repeat (4) tick();
    check("t4_pre_valid", inst_valid, 1);
    check("t4_pre_rvalid_req", imem_req, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t4_valid", inst_valid, 0);
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h200);
    check("t4_no_pop", pop_pc_q.size(), 0);
    repeat (4) tick();
    check("t4_pop0_pc", qat(pop_pc_q, 0), 32'h200);
    check("t4_pop0_ins", qat(pop_ins_q, 0), 32'h200);

    // Misaligned redirect.
    do_reset();
    imem_gnt = 1'b0;
    inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("t6_fault", fetch_fault, 1);
    check("t6_req", imem_req, 0);
    imem_gnt = 1'b1;
    repeat (3) tick();
    check("t6_hold_req", imem_req, 0);
    check("t6_hold_fault", fetch_fault, 1);
    check("t6_no_grant", addr_q.size(), 0);
    imem_gnt = 1'b0;
`else
    check("t6_fault", fetch_fault, 0);
    check("t6_req", imem_req, 1);
    check("t6_addr", imem_addr, 32'h100);
`endif
    redirect_valid = 1'b1;
    redirect_pc = 32'h104;
    tick();
    redirect_valid = 1'b0;
    check("t6_clear_fault", fetch_fault, 0);
    check("t6_resume_req", imem_req, 1);
    check("t6_resume_addr", imem_addr, 32'h104);
    imem_gnt = 1'b1;
    repeat (3) tick();
    check("t6_grant0", qat(addr_q, 0), 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
